// File: rtl/adc_dac_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adc_dac_pkg
//  Brief    : Shared constants for the SAR ADC controller and the DAC stage.
//  Revision : 1.0 - initial release
// ============================================================================
package adc_dac_pkg;

    localparam int c_default_width         = 10;
    localparam int c_default_sample_cycles = 2;
    localparam int c_cnt_w                 = 4;
    localparam int c_state_w               = 2;

    localparam logic [c_state_w-1:0] c_st_idle    = 2'd0;
    localparam logic [c_state_w-1:0] c_st_sample  = 2'd1;
    localparam logic [c_state_w-1:0] c_st_convert = 2'd2;
    localparam logic [c_state_w-1:0] c_st_done    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sar_adc_ctrl
//  Brief    : Successive-approximation ADC controller with registered outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module sar_adc_ctrl
    import adc_dac_pkg::*;
#(
    parameter int WIDTH         = c_default_width,
    parameter int SAMPLE_CYCLES = c_default_sample_cycles
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             comp_in,
    output logic             sample_hold,
    output logic [WIDTH-1:0] dac_trial,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             busy
);

    localparam int              c_bit_w = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_msb  = c_one << (WIDTH - 1);

    logic [c_state_w-1:0] r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_bit_w-1:0]   r_bit_idx;
    logic [WIDTH-1:0]     r_result;
    logic [WIDTH-1:0]     r_dac_trial;
    logic [WIDTH-1:0]     r_data_out;
    logic                 r_sample_hold;
    logic                 r_valid;
    logic                 r_busy;

    logic [c_state_w-1:0] w_state_nxt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [c_bit_w-1:0]   w_bit_idx_nxt;
    logic [WIDTH-1:0]     w_result_nxt;
    logic [WIDTH-1:0]     w_dac_trial_nxt;
    logic [WIDTH-1:0]     w_data_out_nxt;
    logic                 w_sample_hold_nxt;
    logic                 w_valid_nxt;
    logic                 w_busy_nxt;
    logic [WIDTH-1:0]     w_mask;

    assign w_mask = c_one << r_bit_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_cnt         <= '0;
            r_bit_idx     <= '0;
            r_result      <= '0;
            r_dac_trial   <= '0;
            r_data_out    <= '0;
            r_sample_hold <= 1'b0;
            r_valid       <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_bit_idx     <= w_bit_idx_nxt;
            r_result      <= w_result_nxt;
            r_dac_trial   <= w_dac_trial_nxt;
            r_data_out    <= w_data_out_nxt;
            r_sample_hold <= w_sample_hold_nxt;
            r_valid       <= w_valid_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_bit_idx_nxt     = r_bit_idx;
        w_result_nxt      = r_result;
        w_data_out_nxt    = r_data_out;
        w_dac_trial_nxt   = '0;
        w_sample_hold_nxt = 1'b0;
        w_valid_nxt       = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_nxt       = c_st_sample;
                    w_cnt_nxt         = c_cnt_w'(SAMPLE_CYCLES - 1);
                    w_result_nxt      = '0;
                    w_sample_hold_nxt = 1'b1;
                end
            end
            c_st_sample: begin
                if (r_cnt == '0) begin
                    w_state_nxt     = c_st_convert;
                    w_bit_idx_nxt   = c_bit_w'(WIDTH - 1);
                    w_dac_trial_nxt = c_msb;
                end else begin
                    w_cnt_nxt         = r_cnt - c_cnt_w'(1);
                    w_sample_hold_nxt = 1'b1;
                end
            end
            c_st_convert: begin
                // The trial code already carries the decided bits plus the bit under test.
                w_result_nxt = comp_in ? r_dac_trial : r_result;
                if (r_bit_idx == '0) begin
                    w_state_nxt    = c_st_done;
                    w_data_out_nxt = w_result_nxt;
                    w_valid_nxt    = 1'b1;
                end else begin
                    w_bit_idx_nxt   = r_bit_idx - c_bit_w'(1);
                    w_dac_trial_nxt = w_result_nxt | (w_mask >> 1);
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase

        w_busy_nxt = (w_state_nxt != c_st_idle);
    end

    assign sample_hold = r_sample_hold;
    assign dac_trial   = r_dac_trial;
    assign data_out    = r_data_out;
    assign valid       = r_valid;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sar_adc_ctrl
//  Brief    : Scoreboard bench for sar_adc_ctrl with an ideal analog comparator.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sar_adc_ctrl;

    localparam int W  = 10;
    localparam int SC = 2;

    typedef struct {
        int vcyc;
        int code;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic         comp_in;
    logic         sample_hold;
    logic [W-1:0] dac_trial;
    logic [W-1:0] data_out;
    logic         valid;
    logic         busy;

    int   analog;
    int   cyc;
    int   n_run;
    int   n_fail;
    exp_t sb[$];

    // Reference conversion state, expressed as cycle offsets from the accepted start.
    bit   act;
    int   act_e0;
    int   act_code;
    int   next_free;
    int   exp_data;

    sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .comp_in     (comp_in),
        .sample_hold (sample_hold),
        .dac_trial   (dac_trial),
        .data_out    (data_out),
        .valid       (valid),
        .busy        (busy)
    );

    assign comp_in = (analog >= int'(dac_trial));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, int actual, int expected);
        n_run++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        cyc++;
        if (rst) begin
            act       = 1'b0;
            next_free = 0;
        end else begin
            if (act && cyc == act_e0 + SC) begin
                act_code = analog;
                sb.push_back('{vcyc: cyc + W, code: analog});
            end
            if (act && cyc == act_e0 + SC + W + 1) act = 1'b0;
            if (start && cyc >= next_free) begin
                act       = 1'b1;
                act_e0    = cyc;
                next_free = cyc + SC + W + 2;
            end
        end
    end

    always @(negedge clk) begin
        int   off;
        int   bi;
        int   exp_trial;
        bit   exp_v;
        exp_t e;
        if (rst) begin
            sb.delete();
            exp_data = 0;
        end
        if (sb.size() > 0 && sb[0].vcyc < cyc) begin
            e = sb.pop_front();
            chk("missed_valid", 0, 1);
        end
        exp_v = (sb.size() > 0) && (sb[0].vcyc == cyc);
        chk("valid", int'(valid), int'(exp_v));
        if (exp_v) begin
            e = sb.pop_front();
            chk("data_out", int'(data_out), e.code);
            exp_data = e.code;
        end else begin
            chk("data_hold", int'(data_out), exp_data);
        end
        off       = cyc - act_e0;
        exp_trial = 0;
        if (act && off >= SC && off < SC + W) begin
            bi        = W - 1 - (off - SC);
            exp_trial = ((act_code >> (bi + 1)) << (bi + 1)) | (1 << bi);
        end
        chk("dac_trial", int'(dac_trial), exp_trial);
        chk("sample_hold", int'(sample_hold), int'(act && off < SC));
        chk("busy", int'(busy), int'(act));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic conv(input int a);
        analog = a;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
        tick(SC + W + 2);
    endtask

    initial begin
        int k;
        cyc       = 0;
        n_run     = 0;
        n_fail    = 0;
        act       = 1'b0;
        act_e0    = 0;
        act_code  = 0;
        next_free = 0;
        exp_data  = 0;
        analog    = 0;
        start     = 1'b0;
        rst       = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);

        conv(512);
        conv(1023);
        conv(0);

        // Second start pulse lands mid-conversion and must be dropped.
        analog = 341;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
        tick(5);
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
        tick(SC + W);

        // Abort during the bit-5 trial.
        analog = 900;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
        tick(SC + (W - 1 - 5));
        #1 rst = 1'b1;
        #1;
        chk("rst_sample_hold", int'(sample_hold), 0);
        chk("rst_dac_trial", int'(dac_trial), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        conv(700);

        // Held start: analog changes during each SAMPLE window.
        analog = 100;
        start  = 1'b1;
        tick(1);
        tick(SC + W + 2);
        tick(1);
        analog = 200;
        tick(SC + W + 2);
        analog = 300;
        tick(1);
        start = 1'b0;
        tick(SC + W + 2);

        for (int i = 0; i < 20; i++) begin
            tick($urandom_range(0, 3));
            analog = $urandom_range(0, (1 << W) - 1);
            start  = 1'b1;
            tick(1);
            start  = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(1, 10);
                tick(k);
                start = 1'b1;
                tick(1);
                start = 1'b0;
                tick(SC + W + 1 - k);
            end else begin
                tick(SC + W + 2);
            end
        end

        tick(3);
        chk("pending_results", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
